// File: rtl/rect_drag_ctl_if.sv
// rect_drag_ctl_if
// Bundles the signals between the mouse/timing side and the rectangle
// drag controller.
//   vblnk        vertical blank from the timing chain
//   mouse_xpos   mouse x, already in the pclk domain
//   mouse_ypos   mouse y, already in the pclk domain
//   mouse_left   left button, already in the pclk domain
//   xpos, ypos   registered rectangle top-left corner
//   dragging     high while the rectangle is being dragged
//   frame_tick   one-pclk pulse marking the start of vertical blank
// master: drives the mouse/timing inputs and observes the position.
// slave:  the controller itself.
interface rect_drag_ctl_if;
  logic        vblnk;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        dragging;
  logic        frame_tick;

  modport master (
    output vblnk, mouse_xpos, mouse_ypos, mouse_left,
    input  xpos, ypos, dragging, frame_tick
  );

  modport slave (
    input  vblnk, mouse_xpos, mouse_ypos, mouse_left,
    output xpos, ypos, dragging, frame_tick
  );
endinterface

// File: rtl/rect_drag_ctl.sv
// rect_drag_ctl
// Frame-synchronous drag-and-drop controller for the rectangle drawing
// stage. Once per frame, at the rising edge of vblnk, it decides where the
// rectangle is drawn, so the drawn position never changes mid-frame.
// Ports:
//   pclk  pixel clock, sole clock
//   rst   synchronous, active-low reset
//   bus   rect_drag_ctl_if.slave: vblnk and mouse inputs in,
//         xpos/ypos/dragging/frame_tick out (all registered)
module rect_drag_ctl #(
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int INIT_X   = 376,
  parameter int INIT_Y   = 268
) (
  input logic            pclk,
  input logic            rst,
  rect_drag_ctl_if.slave bus
);

  localparam logic [11:0] MAX_X  = 12'(SCREEN_W - RECT_W);
  localparam logic [11:0] MAX_Y  = 12'(SCREEN_H - RECT_H);
  localparam logic [12:0] W13    = 13'(RECT_W);
  localparam logic [12:0] H13    = 13'(RECT_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAG  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        vblnk_d;
  logic        tick;
  logic        hit;
  logic [11:0] xpos_q, ypos_q, offx_q, offy_q;
  logic [11:0] xpos_nxt, ypos_nxt, offx_nxt, offy_nxt;
  logic        dragging_q, frame_tick_q;
  logic signed [12:0] tgt_x, tgt_y;

  // A target is never above 4095, so once the sign bit is clear the
  // low 12 bits can be compared unsigned against the limit.
  function automatic logic [11:0] clamp(input logic signed [12:0] t,
                                        input logic [11:0] hi);
    if (t[12])
      return 12'd0;
    else if (t[11:0] > hi)
      return hi;
    else
      return t[11:0];
  endfunction

  assign tick = bus.vblnk & ~vblnk_d;

  // Hit test done in 13 bits so xpos+RECT_W cannot wrap; right and
  // bottom edges are exclusive.
  assign hit = ({1'b0, bus.mouse_xpos} >= {1'b0, xpos_q}) &
               ({1'b0, bus.mouse_xpos} <  ({1'b0, xpos_q} + W13)) &
               ({1'b0, bus.mouse_ypos} >= {1'b0, ypos_q}) &
               ({1'b0, bus.mouse_ypos} <  ({1'b0, ypos_q} + H13));

  assign tgt_x = $signed({1'b0, bus.mouse_xpos}) - $signed({1'b0, offx_q});
  assign tgt_y = $signed({1'b0, bus.mouse_ypos}) - $signed({1'b0, offy_q});

  // Next-state logic; nothing moves except on the frame tick. A press
  // that starts off the rectangle parks in ARMED until released.
  always_comb begin
    state_nxt = state;
    xpos_nxt  = xpos_q;
    ypos_nxt  = ypos_q;
    offx_nxt  = offx_q;
    offy_nxt  = offy_q;
    if (tick) begin
      case (state)
        IDLE: begin
          if (bus.mouse_left) begin
            if (hit) begin
              state_nxt = DRAG;
              offx_nxt  = bus.mouse_xpos - xpos_q;
              offy_nxt  = bus.mouse_ypos - ypos_q;
            end else begin
              state_nxt = ARMED;
            end
          end
        end
        ARMED: begin
          if (!bus.mouse_left)
            state_nxt = IDLE;
        end
        DRAG: begin
          if (bus.mouse_left) begin
            xpos_nxt = clamp(tgt_x, MAX_X);
            ypos_nxt = clamp(tgt_y, MAX_Y);
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // vblnk_d resets high so a vblnk already asserted at reset release
  // does not produce a tick.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state        <= IDLE;
      vblnk_d      <= 1'b1;
      xpos_q       <= 12'(INIT_X);
      ypos_q       <= 12'(INIT_Y);
      offx_q       <= 12'd0;
      offy_q       <= 12'd0;
      dragging_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      vblnk_d      <= bus.vblnk;
      xpos_q       <= xpos_nxt;
      ypos_q       <= ypos_nxt;
      offx_q       <= offx_nxt;
      offy_q       <= offy_nxt;
      dragging_q   <= (state_nxt == DRAG);
      frame_tick_q <= tick;
    end
  end

  assign bus.xpos       = xpos_q;
  assign bus.ypos       = ypos_q;
  assign bus.dragging   = dragging_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rect_drag_ctl.sv
// tb_rect_drag_ctl
// Self-checking bench for rect_drag_ctl: a vector table of whole frames
// with fixed expected positions, hand-written reset/vblnk sequences, and a
// randomized phase compared every cycle against a behavioural model.
module tb_rect_drag_ctl;

  localparam int INIT_X = 376;
  localparam int INIT_Y = 268;
  localparam int RECT_W = 48;
  localparam int RECT_H = 64;
  localparam int MAX_X  = 800 - RECT_W;
  localparam int MAX_Y  = 600 - RECT_H;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DRAG  = 2;

  typedef struct {
    bit do_reset;
    int mx;
    int my;
    bit left;
    int ex;
    int ey;
    bit edrag;
  } vec_t;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  bit   vblnk_b = 1'b0;
  bit   left_b  = 1'b0;
  int   mx_i = 0;
  int   my_i = 0;

  int errors = 0;
  int checks = 0;

  // Model state: position, grab offset, mode, last vblnk, expected tick
  int m_x, m_y, m_offx, m_offy, m_mode;
  bit m_vd, m_tick;

  vec_t vecs[$];

  rect_drag_ctl_if bus();

  assign bus.vblnk      = vblnk_b;
  assign bus.mouse_xpos = 12'(mx_i);
  assign bus.mouse_ypos = 12'(my_i);
  assign bus.mouse_left = left_b;

  rect_drag_ctl #(
    .RECT_W(48), .RECT_H(64), .SCREEN_W(800), .SCREEN_H(600),
    .INIT_X(376), .INIT_Y(268)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Behavioural model of one clock edge, written from the frame rules.
  task automatic modelEdge();
    if (!rst) begin
      m_x = INIT_X; m_y = INIT_Y; m_offx = 0; m_offy = 0;
      m_mode = M_IDLE; m_vd = 1'b1; m_tick = 1'b0;
      return;
    end
    m_tick = vblnk_b && !m_vd;
    m_vd   = vblnk_b;
    if (!m_tick) return;
    case (m_mode)
      M_IDLE: if (left_b) begin
        if (mx_i >= m_x && mx_i < m_x + RECT_W &&
            my_i >= m_y && my_i < m_y + RECT_H) begin
          m_mode = M_DRAG; m_offx = mx_i - m_x; m_offy = my_i - m_y;
        end else begin
          m_mode = M_ARMED;
        end
      end
      M_ARMED: if (!left_b) m_mode = M_IDLE;
      default: if (left_b) begin
        m_x = clampInt(mx_i - m_offx, MAX_X);
        m_y = clampInt(my_i - m_offy, MAX_Y);
      end else begin
        m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic applyStimulus(input bit v, input int mx, input int my, input bit l);
    vblnk_b = v; mx_i = mx; my_i = my; left_b = l;
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if (int'(bus.xpos) != m_x || int'(bus.ypos) != m_y ||
        bus.dragging != (m_mode == M_DRAG) || bus.frame_tick != m_tick) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got x=%0d y=%0d drag=%0b tick=%0b, want x=%0d y=%0d drag=%0b tick=%0b",
               name, $time, bus.xpos, bus.ypos, bus.dragging, bus.frame_tick,
               m_x, m_y, (m_mode == M_DRAG), m_tick);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    modelEdge();
    #1;
    checkOutput("cycle");
  endtask

  task automatic doReset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Two cycles of vblnk low then three high: exactly one tick per call.
  task automatic runFrame(input int mx, input int my, input bit l, output int pulses);
    pulses = 0;
    applyStimulus(1'b0, mx, my, l);
    repeat (2) begin step(); pulses += int'(bus.frame_tick); end
    vblnk_b = 1'b1;
    repeat (3) begin step(); pulses += int'(bus.frame_tick); end
  endtask

  initial begin
    int pulses;
    int lowLen, highLen;

    vecs.push_back('{1'b1,    0,    0, 1'b0, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  400,  300, 1'b1, 376, 268, 1'b1});
    vecs.push_back('{1'b0,  500,  350, 1'b1, 476, 318, 1'b1});
    vecs.push_back('{1'b0,  500,  350, 1'b0, 476, 318, 1'b0});
    vecs.push_back('{1'b1,   10,   10, 1'b1, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  400,  300, 1'b1, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  400,  300, 1'b1, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  400,  300, 1'b0, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  400,  300, 1'b1, 376, 268, 1'b1});
    vecs.push_back('{1'b0,    5,    5, 1'b1,   0,   0, 1'b1});
    vecs.push_back('{1'b0, 4095, 4095, 1'b1, 752, 536, 1'b1});
    vecs.push_back('{1'b0, 4095, 4095, 1'b0, 752, 536, 1'b0});
    vecs.push_back('{1'b1,  424,  300, 1'b1, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  424,  300, 1'b0, 376, 268, 1'b0});
    vecs.push_back('{1'b0,  423,  331, 1'b1, 376, 268, 1'b1});
    vecs.push_back('{1'b0,  424,  332, 1'b1, 377, 269, 1'b1});
    vecs.push_back('{1'b0,  424,  332, 1'b0, 377, 269, 1'b0});

    // Power-on reset and three idle frames
    applyStimulus(1'b0, 0, 0, 1'b0);
    doReset();
    checkValue("reset xpos", int'(bus.xpos), 376);
    checkValue("reset ypos", int'(bus.ypos), 268);
    checkValue("reset dragging", int'(bus.dragging), 0);
    checkValue("reset frame_tick", int'(bus.frame_tick), 0);
    for (int f = 0; f < 3; f++) begin
      runFrame(0, 0, 1'b0, pulses);
      checkValue($sformatf("idle frame%0d pulses", f), pulses, 1);
      checkValue($sformatf("idle frame%0d xpos", f), int'(bus.xpos), 376);
      checkValue($sformatf("idle frame%0d ypos", f), int'(bus.ypos), 268);
    end

    // Vector table: one frame per record
    foreach (vecs[i]) begin
      if (vecs[i].do_reset) doReset();
      runFrame(vecs[i].mx, vecs[i].my, vecs[i].left, pulses);
      checkValue($sformatf("vec%0d pulses", i), pulses, 1);
      checkValue($sformatf("vec%0d xpos", i), int'(bus.xpos), vecs[i].ex);
      checkValue($sformatf("vec%0d ypos", i), int'(bus.ypos), vecs[i].ey);
      checkValue($sformatf("vec%0d dragging", i), int'(bus.dragging), int'(vecs[i].edrag));
    end

    // Reset in the middle of a drag
    doReset();
    runFrame(400, 300, 1'b1, pulses);
    runFrame(524, 350, 1'b1, pulses);
    checkValue("middrag xpos before", int'(bus.xpos), 500);
    applyStimulus(1'b0, 524, 350, 1'b1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkValue("middrag reset xpos", int'(bus.xpos), 376);
    checkValue("middrag reset ypos", int'(bus.ypos), 268);
    checkValue("middrag reset dragging", int'(bus.dragging), 0);

    // Reset released while vblnk is already high
    vblnk_b = 1'b1;
    doReset();
    pulses = 0;
    repeat (4) begin step(); pulses += int'(bus.frame_tick); end
    checkValue("vblnk high at release pulses", pulses, 0);
    runFrame(0, 0, 1'b0, pulses);
    checkValue("first frame after release pulses", pulses, 1);

    // Mouse wandering between ticks must not move the rectangle
    runFrame(400, 300, 1'b1, pulses);
    runFrame(410, 310, 1'b1, pulses);
    checkValue("between ticks xpos start", int'(bus.xpos), 386);
    vblnk_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mx_i = int'($urandom_range(0, 4095));
      my_i = int'($urandom_range(0, 4095));
      step();
    end
    checkValue("between ticks xpos", int'(bus.xpos), 386);
    checkValue("between ticks ypos", int'(bus.ypos), 278);
    checkValue("between ticks dragging", int'(bus.dragging), 1);

    // Randomized frames against the model
    for (int f = 0; f < 300; f++) begin
      lowLen  = int'($urandom_range(1, 4));
      highLen = int'($urandom_range(1, 4));
      vblnk_b = 1'b0;
      for (int c = 0; c < lowLen + highLen; c++) begin
        if (c == lowLen) vblnk_b = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          mx_i = int'($urandom_range(0, 4095));
          my_i = int'($urandom_range(0, 4095));
        end else begin
          mx_i = clampInt(m_x + int'($urandom_range(0, 72)) - 12, 4095);
          my_i = clampInt(m_y + int'($urandom_range(0, 88)) - 12, 4095);
        end
        if ($urandom_range(0, 4) == 0) left_b = ~left_b;
        rst = ($urandom_range(0, 99) != 0);
        step();
      end
      rst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
